// File: rtl/shake_pkg.sv
// ----------------------------------------------------------------------------
// shake_pkg : shared constants, FSM encoding and rate helper for the squeezer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package shake_pkg;

  localparam int W             = 64;
  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;
  localparam int RATE_MAX      = 1344;
  localparam int IDX_W         = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    STREAM   = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] rate_words(input logic mode);
    return mode ? IDX_W'(RATE256_WORDS) : IDX_W'(RATE128_WORDS);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shake_squeezer_if.sv
// ----------------------------------------------------------------------------
// shake_squeezer_if : control, block-load and output-stream signals of the squeezer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface shake_squeezer_if #(
  parameter int LEN_W = 32
);
  logic                          start_i;
  logic                          mode_i;
  logic [LEN_W-1:0]              out_len_i;
  logic [shake_pkg::RATE_MAX-1:0] block_i;
  logic                          block_valid_i;
  logic                          block_ready_o;
  logic                          perm_req_o;
  logic [shake_pkg::W-1:0]       data_o;
  logic                          valid_o;
  logic                          ready_i;
  logic                          last_o;
  logic                          busy_o;
  logic                          done_o;

  modport slave (
    input  start_i, mode_i, out_len_i, block_i, block_valid_i, ready_i,
    output block_ready_o, perm_req_o, data_o, valid_o, last_o, busy_o, done_o
  );

  modport master (
    output start_i, mode_i, out_len_i, block_i, block_valid_i, ready_i,
    input  block_ready_o, perm_req_o, data_o, valid_o, last_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/piso_shreg.sv
// ----------------------------------------------------------------------------
// piso_shreg : parallel-in / serial-out word shift register, word 0 presented first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module piso_shreg #(
  parameter int W     = shake_pkg::W,
  parameter int WORDS = shake_pkg::RATE128_WORDS
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               load,
  input  wire logic               shift,
  input  wire logic [W*WORDS-1:0] din,
  output logic      [W-1:0]       dout
);

  logic [W*WORDS-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {{W{1'b0}}, sr[W*WORDS-1:W]};
    end
  end

  assign dout = sr[W-1:0];

endmodule

`default_nettype wire

// File: rtl/shake_squeezer.sv
// ----------------------------------------------------------------------------
// shake_squeezer : streams permuted rate blocks out as W-bit words, requesting
//                  further permutations until the requested length is emitted
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module shake_squeezer
  import shake_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  shake_squeezer_if.slave  bus
);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] rate;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] remaining;
  logic             load;
  logic             shift;
  logic             done_set;
  logic             perm_set;
  logic             done_q;
  logic             perm_q;
  logic             start_ok;
  logic [W-1:0]     word0;

  assign start_ok = (state == IDLE) && bus.start_i && (bus.out_len_i != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    done_set   = 1'b0;
    perm_set   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.out_len_i != '0) begin
            state_next = WAIT_BLK;
          end else begin
            done_set = 1'b1;
          end
        end
      end
      WAIT_BLK: begin
        if (bus.block_valid_i) begin
          load       = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (bus.ready_i) begin
          shift = 1'b1;
          // Final word wins over block exhaustion: no permutation is owed.
          if (remaining == LEN_W'(1)) begin
            state_next = IDLE;
            done_set   = 1'b1;
          end else if (idx == rate - IDX_W'(1)) begin
            state_next = WAIT_BLK;
            perm_set   = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate      <= '0;
      idx       <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      perm_q    <= 1'b0;
    end else begin
      done_q <= done_set;
      perm_q <= perm_set;
      if (start_ok) begin
        rate      <= rate_words(bus.mode_i);
        remaining <= bus.out_len_i;
      end
      if (load) begin
        idx <= '0;
      end else if (shift) begin
        idx       <= idx + IDX_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  piso_shreg #(
    .W     (W),
    .WORDS (RATE_MAX / W)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (bus.block_i),
    .dout  (word0)
  );

  assign bus.block_ready_o = (state == WAIT_BLK);
  assign bus.valid_o       = (state == STREAM);
  assign bus.data_o        = word0;
  assign bus.last_o        = (state == STREAM) && (remaining == LEN_W'(1));
  assign bus.busy_o        = (state != IDLE);
  assign bus.perm_req_o    = perm_q;
  assign bus.done_o        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shake_squeezer.sv
// ----------------------------------------------------------------------------
// tb_shake_squeezer : directed + randomized self-checking bench for shake_squeezer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_shake_squeezer;
  import shake_pkg::*;

  localparam int LEN_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Reference blocks: blk[b][k] is word k of the b-th block handed to the DUT.
  logic [63:0] blk [0:7][0:20];

  always #5 clk = ~clk;

  shake_squeezer_if #(.LEN_W(LEN_W)) bus ();

  shake_squeezer #(.LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_blocks(input bit counting);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 21; k++)
        blk[b][k] = counting ? 64'(b * 21 + k + 1) : {$urandom, $urandom};
  endtask

  task automatic drive_block(input int b);
    for (int k = 0; k < 21; k++)
      bus.block_i[64*k +: 64] = blk[b][k];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_block_ready"}, 64'(bus.block_ready_o), 64'd0);
    check({tag, "_perm_req"},    64'(bus.perm_req_o),    64'd0);
    check({tag, "_valid"},       64'(bus.valid_o),       64'd0);
    check({tag, "_last"},        64'(bus.last_o),        64'd0);
    check({tag, "_busy"},        64'(bus.busy_o),        64'd0);
    check({tag, "_done"},        64'(bus.done_o),        64'd0);
    check({tag, "_data"},        bus.data_o,             64'd0);
  endtask

  // Output word n of a squeeze is word (n mod rate) of block (n / rate).
  task automatic run_squeeze(input bit mode, input int len, input int stall_pct, input int abort_at);
    int          rate;
    int          n;
    int          blk_n;
    int          perms;
    int          cyc;
    bit          exp_done;
    bit          exp_perm;
    bit          exp_valid;
    bit          finished;
    bit          held;
    logic [63:0] held_data;
    rate      = mode ? RATE256_WORDS : RATE128_WORDS;
    n         = 0;
    blk_n     = 0;
    perms     = 0;
    cyc       = 0;
    exp_done  = 0;
    exp_perm  = 0;
    exp_valid = 0;
    finished  = 0;
    held      = 0;
    held_data = '0;

    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.mode_i    = mode;
    bus.out_len_i = LEN_W'(len);
    @(negedge clk);
    bus.start_i   = 1'b0;
    check("busy_after_start", 64'(bus.busy_o), 64'd1);

    while (!finished && cyc < 2000) begin
      cyc++;
      check("perm_req", 64'(bus.perm_req_o), 64'(exp_perm));
      check("done", 64'(bus.done_o), 64'(exp_done));
      if (bus.perm_req_o) perms++;
      if (exp_perm) check("ready_with_perm", 64'(bus.block_ready_o), 64'd1);
      if (exp_valid) check("valid_after_load", 64'(bus.valid_o), 64'd1);
      if (exp_done) begin
        check("busy_at_done", 64'(bus.busy_o), 64'd0);
        finished = 1;
      end
      exp_perm  = 0;
      exp_done  = 0;
      exp_valid = 0;
      bus.block_valid_i = 1'b0;
      bus.ready_i       = 1'b0;
      if (!finished && abort_at >= 0 && n == abort_at) break;

      if (!finished && bus.block_ready_o) begin
        check("valid_in_wait", 64'(bus.valid_o), 64'd0);
        if (stall_pct == 0 || $urandom_range(99) >= stall_pct) begin
          drive_block(blk_n);
          bus.block_valid_i = 1'b1;
          blk_n++;
          exp_valid = 1;
        end
      end

      if (!finished && bus.valid_o) begin
        if (held) check("data_held", bus.data_o, held_data);
        check("data", bus.data_o, blk[n / rate][n % rate]);
        check("last", 64'(bus.last_o), 64'(n == len - 1));
        if (stall_pct == 0 || $urandom_range(99) >= stall_pct) begin
          bus.ready_i = 1'b1;
          held        = 0;
          n++;
          if (n == len) exp_done = 1;
          else if (n % rate == 0) exp_perm = 1;
        end else begin
          held      = 1;
          held_data = bus.data_o;
        end
      end
      if (!finished) @(negedge clk);
    end

    if (abort_at < 0) begin
      check("squeeze_finished", 64'(finished), 64'd1);
      check("words_emitted", 64'(n), 64'(len));
      check("perm_count", 64'(perms), 64'((len - 1) / rate));
    end
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.mode_i        = 1'b0;
    bus.out_len_i     = '0;
    bus.block_i       = '0;
    bus.block_valid_i = 1'b0;
    bus.ready_i       = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    fill_blocks(1'b1);
    run_squeeze(1'b0, 4, 0, -1);

    fill_blocks(1'b0);
    run_squeeze(1'b1, 20, 0, -1);

    fill_blocks(1'b0);
    run_squeeze(1'b0, 21, 0, -1);

    fill_blocks(1'b0);
    run_squeeze(1'b0, 30, 0, -1);
    run_squeeze(1'b0, 30, 40, -1);
    run_squeeze(1'b1, 40, 30, -1);

    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.out_len_i = '0;
    @(negedge clk);
    bus.start_i   = 1'b0;
    check("zero_len_done", 64'(bus.done_o), 64'd1);
    check("zero_len_busy", 64'(bus.busy_o), 64'd0);
    check("zero_len_block_ready", 64'(bus.block_ready_o), 64'd0);
    check("zero_len_valid", 64'(bus.valid_o), 64'd0);
    @(negedge clk);
    check("zero_len_done_pulse", 64'(bus.done_o), 64'd0);
    check("zero_len_block_ready2", 64'(bus.block_ready_o), 64'd0);
    check("zero_len_valid2", 64'(bus.valid_o), 64'd0);

    fill_blocks(1'b1);
    run_squeeze(1'b0, 10, 0, 5);
    check("mid_stream_valid", 64'(bus.valid_o), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("mid_reset");
    run_squeeze(1'b0, 2, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shake_squeezer.md
# shake_squeezer

Squeeze-side output stage of the SHAKE core: accepts a full rate block from the Keccak permutation in parallel and streams it out as 64-bit words over a valid/ready interface until the requested output length is produced. It is the read-out counterpart of the absorb-side loading path. Whenever a block is exhausted and more output is still owed, it requests another permutation.

## Interface

Parameters:
- W, 64, output word width (one Keccak lane)
- RATE_MAX, 1344, width of the parallel block input in bits (SHAKE128 rate)
- LEN_W, 32, width of the output-length counter (length counted in words)

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- start_i  in  1  begin a squeeze; samples mode_i and out_len_i; ignored while busy_o=1
- mode_i  in  1  0 = SHAKE128 (rate 21 words), 1 = SHAKE256 (rate 17 words)
- out_len_i  in  LEN_W  number of W-bit words to emit
- block_i  in  RATE_MAX  rate portion of the state, word k = bits [64k+63:64k]
- block_valid_i  in  1  block_i holds a fresh permuted block
- block_ready_o  out  1  squeezer can take a block
- perm_req_o  out  1  one-cycle pulse: run another permutation
- data_o  out  W  current output word
- valid_o  out  1  data_o is valid
- ready_i  in  1  downstream accepts data_o
- last_o  out  1  qualifies the final word of the squeeze
- busy_o  out  1  squeeze in progress
- done_o  out  1  one-cycle pulse after the final word is accepted

## Operation

- States: IDLE, WAIT_BLK, STREAM.
- IDLE:
  - start_i with out_len_i>0: latch the rate (21 or 17 words) and remaining = out_len_i, then go to WAIT_BLK.
  - start_i with out_len_i=0: pulse done_o on the next cycle and stay in IDLE.
- WAIT_BLK:
  - block_ready_o=1.
  - block_valid_i&&block_ready_o: load block_i into the shift register, set idx=0, go to STREAM.
  - The first block needs no perm_req_o; the absorb path has already produced it.
- STREAM:
  - valid_o=1 and data_o = word 0 of the shift register.
  - last_o = (remaining==1).
  - On a handshake (valid_o&&ready_i): shift right by W, idx++, remaining--.
  - Handshake with remaining==1: go to IDLE and pulse done_o on the next cycle.
  - Otherwise, handshake with idx==rate-1: pulse perm_req_o on the next cycle and go to WAIT_BLK.
- Bits beyond rate×W in block_i are ignored in SHAKE256 mode.
- Once valid_o is asserted, data_o and last_o stay stable until the handshake occurs.
- busy_o=1 in WAIT_BLK and STREAM.
- Reset (rst_n=0, any state, including mid-stream): go to IDLE and clear every output:
  - block_ready_o, perm_req_o, valid_o, last_o, busy_o, done_o = 0
  - data_o = 0
  - counters cleared

## Timing

- Block accept to first valid_o: 1 cycle (registered).
- Sustained throughput: 1 word/cycle while ready_i=1.
- Last word of a block accepted in cycle t:
  - perm_req_o and block_ready_o are both high in cycle t+1.
  - The earliest next data is in cycle t+2, if block_valid_i is already high at t+1.
- done_o fires in the cycle after the last handshake; busy_o=0 in that same cycle.
- start_i can be accepted in the same cycle that done_o fires.
- remaining and idx are unsigned.
  - remaining never wraps: it is checked for 1 before decrementing.
  - idx wraps only through the WAIT_BLK reload.

## Structure

- shake_pkg holds:
  - W
  - RATE128_WORDS=21 and RATE256_WORDS=17
  - RATE_MAX
  - the state enum {IDLE, WAIT_BLK, STREAM}
- Sub-module piso_shreg: parallel-in/serial-out shift register.
  - Ports: load, shift, parallel in, word-0 out.
  - All word indexing is kept out of the FSM.
- Counters and the mode latch stay in the top module.

## Test plan

- SHAKE128, out_len=4, ready_i tied high, block words k = k+1:
  - data_o = 1, 2, 3, 4 on consecutive cycles
  - last_o on 4
  - done_o the next cycle
  - no perm_req_o
- SHAKE256, out_len=20:
  - 17 words emitted
  - perm_req_o pulses exactly once
  - second block emits 3 words, last_o on the 20th word
- SHAKE128, out_len=21:
  - last_o coincides with idx=20
  - no perm_req_o
  - done_o pulses
- Random ready_i backpressure on out_len=30:
  - data_o and last_o are held stable while valid_o&&!ready_i
  - word sequence is unchanged versus the no-stall run
- out_len=0:
  - done_o one cycle after start_i
  - valid_o and block_ready_o never assert
- rst_n low for 1 cycle mid-STREAM (after word 5 of 10):
  - all outputs 0 the next cycle
  - a new start_i with out_len=2 is accepted and completes normally
